jtkicker_objscan: RTL and testbench

//  Object-table scanner feeding jtkicker_objdraw. Each line it walks object RAM and tests each entry's Y against the line being rendered.
//  For every hit it presents code/x/ysub/pal/flip fields with a draw/busy handshake. Scanning runs during the current line for the next one.

---
 rtl/jtkicker_obj_pkg.sv | 23 ++
 rtl/jtkicker_objscan.sv | 142 ++++++++++++++
 tb/tb_jtkicker_objscan.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jtkicker_obj_pkg.sv
// rtl/jtkicker_obj_pkg.sv - shared constants and FSM encoding for the object scanner
package jtkicker_obj_pkg;

  localparam logic [1:0] BYTE_Y    = 2'd0;
  localparam logic [1:0] BYTE_CODE = 2'd1;
  localparam logic [1:0] BYTE_ATTR = 2'd2;
  localparam logic [1:0] BYTE_X    = 2'd3;

  localparam int ATTR_CODE8 = 7;
  localparam int ATTR_VFLIP = 6;
  localparam int ATTR_HFLIP = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK,
    ST_RDC,
    ST_RDA,
    ST_RDX,
    ST_DRAW,
    ST_ACK
  } scan_state_t;

endpackage

// File: rtl/jtkicker_objscan.sv
// rtl/jtkicker_objscan.sv - object RAM scanner feeding jtkicker_objdraw
// Optional per-line hit limit enabled by JTKICKER_OBJLIMIT_EN.
module jtkicker_objscan
  import jtkicker_obj_pkg::*;
#(
  parameter logic [5:0] OBJ_LAST = 6'd63,
  parameter logic [7:0] YOFFSET  = 8'd1,
  parameter logic [4:0] LIMIT    = 5'd24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen2,
  input  logic       hinit,
  input  logic [8:0] vdump,
  input  logic       flip,
  output logic [7:0] obj_addr,
  input  logic [7:0] obj_dout,
  output logic       draw,
  input  logic       busy,
  output logic [7:0] xpos,
  output logic [3:0] ysub,
  output logic [3:0] pal,
  output logic       hflip,
  output logic       vflip,
  output logic [8:0] code,
  output logic       done
);

  scan_state_t state;
  logic [5:0]  idx;
  logic [7:0]  vrender;
  logic [7:0]  ydiff;
  logic        hit;
  logic        unused_vdump8;

  assign unused_vdump8 = vdump[8];

`ifdef JTKICKER_OBJLIMIT_EN
  logic [4:0] hits;
`else
  logic unused_limit;
  assign unused_limit = ^LIMIT;
`endif

  // Y compare wraps at 8 bits so objects straddling line 0 still hit
  assign vrender = flip ? ~vdump[7:0] : vdump[7:0];
  assign ydiff   = vrender + YOFFSET - obj_dout;
  assign hit     = ydiff[7:4] == 4'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= 6'd0;
      obj_addr <= 8'd0;
      draw     <= 1'b0;
      xpos     <= 8'd0;
      ysub     <= 4'd0;
      pal      <= 4'd0;
      hflip    <= 1'b0;
      vflip    <= 1'b0;
      code     <= 9'd0;
      done     <= 1'b1;
`ifdef JTKICKER_OBJLIMIT_EN
      hits     <= 5'd0;
`endif
    end else if (cen2) begin
      if (hinit) begin
        // a draw already accepted finishes in the draw stage; we just restart
        state    <= ST_CHK;
        idx      <= OBJ_LAST;
        obj_addr <= {OBJ_LAST, BYTE_Y};
        draw     <= 1'b0;
        done     <= 1'b0;
`ifdef JTKICKER_OBJLIMIT_EN
        hits     <= 5'd0;
`endif
      end else begin
        case (state)
          ST_IDLE: done <= 1'b1;
          ST_CHK: begin
            if (hit) begin
              ysub     <= ydiff[3:0];
              obj_addr <= {idx, BYTE_CODE};
              state    <= ST_RDC;
            end else if (idx == 6'd0) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              idx      <= idx - 6'd1;
              obj_addr <= {idx - 6'd1, BYTE_Y};
            end
          end
          ST_RDC: begin
            code[7:0] <= obj_dout;
            obj_addr  <= {idx, BYTE_ATTR};
            state     <= ST_RDA;
          end
          ST_RDA: begin
            code[8]  <= obj_dout[ATTR_CODE8];
            vflip    <= obj_dout[ATTR_VFLIP] ^ flip;
            hflip    <= obj_dout[ATTR_HFLIP] ^ flip;
            pal      <= obj_dout[3:0];
            obj_addr <= {idx, BYTE_X};
            state    <= ST_RDA == ST_RDA ? ST_RDX : ST_RDX;
          end
          ST_RDX: begin
            xpos  <= flip ? 8'd240 - obj_dout : obj_dout;
            state <= ST_DRAW;
          end
          ST_DRAW: begin
            if (!busy) begin
              draw  <= 1'b1;
              state <= ST_ACK;
            end
          end
          ST_ACK: begin
            if (busy) begin
              draw <= 1'b0;
`ifdef JTKICKER_OBJLIMIT_EN
              hits <= hits + 5'd1;
              if (hits + 5'd1 == LIMIT) begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end else
`endif
              if (idx == 6'd0) begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end else begin
                idx      <= idx - 6'd1;
                obj_addr <= {idx - 6'd1, BYTE_Y};
                state    <= ST_CHK;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtkicker_objscan.sv
// tb/tb_jtkicker_objscan.sv - directed and randomized checks of jtkicker_objscan
// Build with or without JTKICKER_OBJLIMIT_EN; expectations follow the macro.
module tb_jtkicker_objscan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen2 = 1'b0;
  logic       hinit = 1'b0;
  logic [8:0] vdump = 9'd0;
  logic       flip = 1'b0;
  logic [7:0] obj_addr;
  logic [7:0] obj_dout = 8'd0;
  logic       draw;
  logic       busy = 1'b0;
  logic [7:0] xpos;
  logic [3:0] ysub;
  logic [3:0] pal;
  logic       hflip;
  logic       vflip;
  logic [8:0] code;
  logic       done;

  jtkicker_objscan dut (
    .clk(clk), .rst(rst), .cen2(cen2), .hinit(hinit), .vdump(vdump), .flip(flip),
    .obj_addr(obj_addr), .obj_dout(obj_dout), .draw(draw), .busy(busy),
    .xpos(xpos), .ysub(ysub), .pal(pal), .hflip(hflip), .vflip(vflip),
    .code(code), .done(done)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cen2 = ~cen2;

  logic [7:0]  ram [256];
  always @(posedge clk) obj_dout <= ram[obj_addr];

  int passed = 0;
  int total  = 0;
  logic force_busy = 1'b1;
  logic [26:0] got_q [$];
  logic [26:0] exp_q [$];

`ifdef JTKICKER_OBJLIMIT_EN
  localparam int MAXHITS = 24;
`else
  localparam int MAXHITS = 64;
`endif

  function automatic logic [26:0] fields();
    return {code, xpos, ysub, pal, hflip, vflip};
  endfunction

  // draw stage: accept each request and stay busy a random while
  initial begin
    forever begin
      @(negedge clk);
      if (!force_busy && draw && !busy) begin
        got_q.push_back(fields());
        busy = 1'b1;
        repeat ($urandom_range(2, 9)) @(negedge clk);
        busy = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic wait_cen();
    @(posedge clk);
    while (!cen2) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] render_plus1(input logic [8:0] vd, input logic fl);
    logic [7:0] v;
    v = vd[7:0];
    if (fl) v = 8'd255 - v;
    return v + 8'd1;
  endfunction

  task automatic build_model(input logic [8:0] vd, input logic fl);
    logic [7:0] r, y, d, c, a, x;
    exp_q.delete();
    r = render_plus1(vd, fl);
    for (int i = 63; i >= 0; i--) begin
      y = ram[i*4]; c = ram[i*4+1]; a = ram[i*4+2]; x = ram[i*4+3];
      d = r - y;
      if (d < 8'd16 && exp_q.size() < MAXHITS)
        exp_q.push_back({a[7], c, fl ? 8'd240 - x : x, d[3:0], a[3:0], a[5] ^ fl, a[6] ^ fl});
    end
  endtask

  task automatic clear_ram(input logic [7:0] r);
    for (int i = 0; i < 64; i++) begin
      ram[i*4]   = r + 8'd100;
      ram[i*4+1] = 8'($urandom);
      ram[i*4+2] = 8'($urandom);
      ram[i*4+3] = 8'($urandom);
    end
  endtask

  task automatic set_obj(input int i, input logic [7:0] y, c, a, x);
    ram[i*4] = y; ram[i*4+1] = c; ram[i*4+2] = a; ram[i*4+3] = x;
  endtask

  task automatic start_line(input logic [8:0] vd, input logic fl);
    vdump = vd; flip = fl;
    got_q.delete();
    build_model(vd, fl);
    hinit = 1'b1;
    wait_cen();
    hinit = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 3000) begin wait_cen(); n++; end
    chk(tag, {31'd0, done}, 32'd1);
    while (busy) @(negedge clk);
  endtask

  task automatic check_draws(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_fields"}, {5'd0, got_q[i]}, {5'd0, exp_q[i]});
  endtask

  function automatic logic [26:0] got(input int i);
    return (i < got_q.size()) ? got_q[i] : 27'h7ffffff;
  endfunction

  initial begin
    logic [26:0] held;
    logic        seen;
    int          n;
    logic [7:0]  r;

    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    wait_cen();
    chk("rst_draw", {31'd0, draw}, 32'd0);
    chk("rst_addr", {24'd0, obj_addr}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd1);
    chk("rst_fields", {5'd0, fields()}, 32'd0);
    force_busy = 1'b0;

    // single hit at the highest index
    clear_ram(render_plus1(9'd99, 1'b0));
    set_obj(63, 8'd100, 8'h5A, 8'h8C, 8'h33);
    start_line(9'd99, 1'b0);
    chk("t1_busy_scan", {31'd0, done}, 32'd0);
    wait_done("t1_done");
    check_draws("t1");
    chk("t1_const", {5'd0, got(0)}, {5'd0, 1'b1, 8'h5A, 8'h33, 4'd0, 4'hC, 1'b0, 1'b0});

    // Y wrap hit
    clear_ram(render_plus1(9'd3, 1'b0));
    set_obj(40, 8'd250, 8'h11, 8'h03, 8'h40);
    start_line(9'd3, 1'b0);
    wait_done("t2a_done");
    check_draws("t2a");
    chk("t2a_ysub", {28'd0, got(0)[9:6]}, 32'd10);

    // ydiff 16 misses, ydiff 15 hits
    clear_ram(render_plus1(9'd71, 1'b0));
    set_obj(20, 8'd88, 8'h22, 8'h01, 8'h10);
    set_obj(10, 8'd56, 8'h33, 8'h02, 8'h20);
    set_obj(5,  8'd57, 8'h44, 8'h04, 8'h30);
    start_line(9'd71, 1'b0);
    wait_done("t2b_done");
    check_draws("t2b");
    chk("t2b_const", {5'd0, got(0)}, {5'd0, 1'b0, 8'h44, 8'h30, 4'd15, 4'h4, 1'b0, 1'b0});

    // draw stage busy for a long time before the request
    force_busy = 1'b1; busy = 1'b1;
    clear_ram(render_plus1(9'd50, 1'b0));
    set_obj(45, 8'd45, 8'h66, 8'h47, 8'h80);
    start_line(9'd50, 1'b0);
    seen = 1'b0;
    repeat (40) begin wait_cen(); seen |= draw; end
    chk("t3_no_draw", {31'd0, seen}, 32'd0);
    chk("t3_fields_ready", {5'd0, fields()}, {5'd0, exp_q[0]});
    busy = 1'b0; force_busy = 1'b0;
    wait_done("t3_done");
    check_draws("t3");

    // abort while a request is pending
    force_busy = 1'b1; busy = 1'b0;
    clear_ram(render_plus1(9'd120, 1'b0));
    set_obj(30, 8'd115, 8'h99, 8'h6A, 8'h55);
    start_line(9'd120, 1'b0);
    n = 0;
    while (!draw && n < 500) begin wait_cen(); n++; end
    chk("t4_draw_up", {31'd0, draw}, 32'd1);
    chk("t4_addr_x", {24'd0, obj_addr}, {24'd0, 6'd30, 2'd3});
    held = fields();
    repeat (10) wait_cen();
    chk("t4_stable", {5'd0, fields()}, {5'd0, held});
    chk("t4_draw_held", {31'd0, draw}, 32'd1);
    hinit = 1'b1;
    wait_cen();
    hinit = 1'b0;
    chk("t4_abort_draw", {31'd0, draw}, 32'd0);
    chk("t4_abort_addr", {24'd0, obj_addr}, 32'd252);
    force_busy = 1'b0;
    wait_done("t4_done");
    check_draws("t4");

    // flipped screen
    clear_ram(render_plus1(9'd100, 1'b1));
    set_obj(12, 8'd150, 8'h77, 8'h25, 8'd16);
    start_line(9'd100, 1'b1);
    wait_done("t5_done");
    check_draws("t5");
    chk("t5_const", {5'd0, got(0)}, {5'd0, 1'b0, 8'h77, 8'd224, 4'd6, 4'd5, 1'b0, 1'b1});

    // crowded line
    r = render_plus1(9'd200, 1'b0);
    clear_ram(r);
    for (int i = 63; i >= 34; i--) ram[i*4] = r - 8'($urandom_range(0, 15));
    start_line(9'd200, 1'b0);
    wait_done("t6_done");
`ifdef JTKICKER_OBJLIMIT_EN
    chk("t6_limit", got_q.size(), 32'd24);
`else
    chk("t6_all", got_q.size(), 32'd30);
`endif
    check_draws("t6");

    // random lines with Y clustered near the render line
    for (int l = 0; l < 6; l++) begin
      logic [8:0] vd;
      logic       fl;
      vd = 9'($urandom_range(0, 511));
      fl = 1'($urandom);
      r = render_plus1(vd, fl);
      clear_ram(r);
      for (int i = 0; i < 64; i++) ram[i*4] = r - 8'($urandom_range(0, 40));
      start_line(vd, fl);
      wait_done("rnd_done");
      check_draws("rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
